// File: rtl/snapshot_pkg.sv
// rtl/snapshot_pkg.sv - state type and address/partition helpers for snapshot_mem_bridge
package snapshot_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM,
      S_RESP
   } state_t;

   function automatic int unsigned rsv_bits(input int unsigned width);
      return $clog2(width / 8);
   endfunction

   function automatic int unsigned part_index(input logic [31:0] byte_addr,
                                              input int unsigned bsv,
                                              input int unsigned cnt);
      logic [31:0] shifted;
      shifted = byte_addr >> bsv;
      return shifted & (cnt - 1);
   endfunction

   function automatic logic lane_misaligned(input logic [31:0] byte_addr,
                                            input int unsigned bsv);
      logic [31:0] lane_mask;
      lane_mask = (32'd1 << bsv) - 32'd1;
      return (byte_addr & lane_mask) != 32'd0;
   endfunction

endpackage

// File: rtl/one_hot_mux.sv
// rtl/one_hot_mux.sv - AND-OR selector driven by a one-hot select vector
module one_hot_mux #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 32
) (
   input  logic [N-1:0]        sel,
   input  logic [N-1:0][W-1:0] data,
   output logic [W-1:0]        dout
);

   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) dout = dout | data[i];
      end
   end

endmodule

// File: rtl/snapshot_mem_bridge.sv
// rtl/snapshot_mem_bridge.sv - narrow register bus to wide memory port via a snapshot word
module snapshot_mem_bridge
   import snapshot_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 32,
   parameter int unsigned BUS_ADDR_WIDTH = 64,
   parameter int unsigned MEM_DATA_WIDTH = 64,
   parameter int unsigned MEM_ADDR_WIDTH = 32,
   parameter bit          WR_COMMIT_LAST = 1'b1,
   parameter bit          STRICT         = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_vld,
   output logic                      ack_vld,
   output logic                      err,
   input  logic [BUS_ADDR_WIDTH-1:0] addr,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic [BUS_DATA_WIDTH-1:0] wr_data,
   output logic [BUS_DATA_WIDTH-1:0] rd_data,
   output logic                      mem_req_vld,
   input  logic                      mem_ack_vld,
   input  logic                      mem_err,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic                      mem_wr_en,
   output logic                      mem_rd_en,
   output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
   input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data
);

   localparam int unsigned PARTITION_CNT = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
   localparam int unsigned RSV           = rsv_bits(MEM_DATA_WIDTH);
   localparam int unsigned BSV           = rsv_bits(BUS_DATA_WIDTH);
   localparam int unsigned PW            = (PARTITION_CNT > 1) ? $clog2(PARTITION_CNT) : 1;
   localparam int unsigned COMMIT_IDX    = WR_COMMIT_LAST ? PARTITION_CNT - 1 : 0;
   localparam logic [PARTITION_CNT-1:0] COMMIT_OH = PARTITION_CNT'(1) << COMMIT_IDX;

   state_t                                     state;
   logic [PARTITION_CNT-1:0][BUS_DATA_WIDTH-1:0] snap;
   logic [PARTITION_CNT-1:0]                   mask;
   logic [31:0]                                tmo_cnt;

   logic [31:0]                                addr_lo;
   logic [PW-1:0]                              part;
   logic [PARTITION_CNT-1:0]                   part_oh;
   logic                                       illegal;
   logic                                       is_commit;
   logic                                       is_fetch;
   logic                                       strict_fail;
   logic                                       tmo_hit;
   logic [BUS_DATA_WIDTH-1:0]                  snap_rd;
   logic [PARTITION_CNT-1:0][BUS_DATA_WIDTH-1:0] commit_word;
   logic                                       unused_addr_bits;

   assign addr_lo          = addr[31:0];
   assign unused_addr_bits = ^addr;
   assign part             = PW'(part_index(addr_lo, BSV, PARTITION_CNT));
   assign part_oh          = PARTITION_CNT'(1) << part;
   assign illegal          = lane_misaligned(addr_lo, BSV) || (wr_en == rd_en);
   assign is_commit        = wr_en && (part_oh == COMMIT_OH);
   assign is_fetch         = rd_en && part_oh[0];
   // Only non-commit partitions must have been written; the commit write supplies its own.
   assign strict_fail      = STRICT && ((mask | COMMIT_OH) != '1);
   assign tmo_hit          = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES - 1);

   always_comb begin
      commit_word = snap;
      for (int i = 0; i < PARTITION_CNT; i++) begin
         if (COMMIT_OH[i]) commit_word[i] = wr_data;
      end
   end

   one_hot_mux #(
      .N(PARTITION_CNT),
      .W(BUS_DATA_WIDTH)
   ) u_rd_mux (
      .sel (part_oh),
      .data(snap),
      .dout(snap_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ack_vld     <= 1'b0;
         err         <= 1'b0;
         rd_data     <= '0;
         mem_req_vld <= 1'b0;
         mem_addr    <= '0;
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_wr_data <= '0;
         snap        <= '0;
         mask        <= '0;
         tmo_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_vld) begin
                  tmo_cnt <= '0;
                  if (illegal) begin
                     state   <= S_RESP;
                     ack_vld <= 1'b1;
                     err     <= 1'b1;
                  end else if (is_commit) begin
                     mask <= '0;
                     if (strict_fail) begin
                        state   <= S_RESP;
                        ack_vld <= 1'b1;
                        err     <= 1'b1;
                     end else begin
                        state            <= S_MEM;
                        mem_req_vld      <= 1'b1;
                        mem_wr_en        <= 1'b1;
                        mem_addr         <= addr[RSV +: MEM_ADDR_WIDTH];
                        mem_wr_data      <= commit_word;
                        snap[COMMIT_IDX] <= wr_data;
                     end
                  end else if (is_fetch) begin
                     state       <= S_MEM;
                     mem_req_vld <= 1'b1;
                     mem_rd_en   <= 1'b1;
                     mem_addr    <= addr[RSV +: MEM_ADDR_WIDTH];
                  end else if (wr_en) begin
                     snap[part] <= wr_data;
                     mask[part] <= 1'b1;
                     state      <= S_RESP;
                     ack_vld    <= 1'b1;
                     err        <= 1'b0;
                  end else begin
                     rd_data <= snap_rd;
                     state   <= S_RESP;
                     ack_vld <= 1'b1;
                     err     <= 1'b0;
                  end
               end
            end
            S_MEM: begin
               // A memory ack on the timeout edge takes priority over the timeout.
               if (mem_ack_vld || tmo_hit) begin
                  state       <= S_RESP;
                  ack_vld     <= 1'b1;
                  err         <= mem_ack_vld ? mem_err : 1'b1;
                  mem_req_vld <= 1'b0;
                  mem_wr_en   <= 1'b0;
                  mem_rd_en   <= 1'b0;
                  mem_addr    <= '0;
                  mem_wr_data <= '0;
                  if (mem_ack_vld && mem_rd_en) begin
                     rd_data <= mem_rd_data[BUS_DATA_WIDTH-1:0];
                     if (!mem_err) snap <= mem_rd_data;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            S_RESP: begin
               state   <= S_IDLE;
               ack_vld <= 1'b0;
               err     <= 1'b0;
               rd_data <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   busy_req_a: assert property (@(posedge clk) disable iff (rst) !(req_vld && state != S_IDLE));

endmodule
